// File: rtl/phase_seq64.sv
// Phase sequencer for the 64-MAC DLA main controller: times FSLD/LEFT/BASE/RIGHT
// phases of the master FSM and produces its start/done inputs.
module phase_seq64 #(
    parameter int FSLD_W = 12,
    parameter int BLK_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              layer_go,
    input  logic              hold,
    input  logic [2:0]        mast_state,
    input  logic [FSLD_W-1:0] cfg_fsld_len,
    input  logic [BLK_W-1:0]  cfg_blk_len,
    output logic              start,
    output logic              flag_fsld_end,
    output logic              left_done,
    output logic              base_done,
    output logic              right_done,
    output logic              active,
    output logic              layer_done,
    output logic [6:0]        base_cnt,
    output logic              err
);

    localparam logic [2:0] M_IDLE  = 3'd0;
    localparam logic [2:0] M_LEFT  = 3'd1;
    localparam logic [2:0] M_BASE  = 3'd2;
    localparam logic [2:0] M_RIGHT = 3'd3;
    localparam logic [2:0] M_FSLD  = 3'd7;

    logic [FSLD_W-1:0] cnt;
    logic [FSLD_W:0]   cnt_inc;
    logic [FSLD_W:0]   fsld_len_ext;
    logic [FSLD_W:0]   blk_len_ext;
    logic              fsld_end;
    logic              blk_end;
    logic              run_ok;
    logic              any_done;
    logic              illegal;
    logic              go_accept;

    // Compare one bit wider so cnt+1 never wraps; a length of 0 acts as 1.
    assign cnt_inc      = {1'b0, cnt} + {{FSLD_W{1'b0}}, 1'b1};
    assign fsld_len_ext = {1'b0, cfg_fsld_len};
    assign blk_len_ext  = {{(FSLD_W + 1 - BLK_W){1'b0}}, cfg_blk_len};
    assign fsld_end     = (cnt_inc >= fsld_len_ext);
    assign blk_end      = (cnt_inc >= blk_len_ext);

    // Handshake with the master FSM: start is a level request while it sits in
    // M_IDLE; each done is a one-cycle pulse the FSM consumes on the same edge.
    assign run_ok        = active & ~hold;
    assign start         = run_ok & (mast_state == M_IDLE);
    assign flag_fsld_end = run_ok & fsld_end & (mast_state == M_FSLD);
    assign left_done     = run_ok & blk_end  & (mast_state == M_LEFT);
    assign base_done     = run_ok & blk_end  & (mast_state == M_BASE);
    assign right_done    = run_ok & blk_end  & (mast_state == M_RIGHT);

    assign any_done  = flag_fsld_end | left_done | base_done | right_done;
    assign illegal   = (mast_state == 3'd4) | (mast_state == 3'd5) | (mast_state == 3'd6);
    assign go_accept = layer_go & ~active;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active     <= 1'b0;
            cnt        <= '0;
            base_cnt   <= '0;
            layer_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (go_accept) begin
                active <= 1'b1;
            end else if (right_done) begin
                active <= 1'b0;
            end

            if (!active || (mast_state == M_IDLE) || any_done) begin
                cnt <= '0;
            end else if (!hold) begin
                cnt <= cnt_inc[FSLD_W-1:0];
            end

            if (go_accept) begin
                base_cnt <= '0;
            end else if (base_done && (base_cnt != 7'h7f)) begin
                base_cnt <= base_cnt + 7'd1;
            end

            layer_done <= right_done;

            if (active && illegal) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phase_seq64.sv
// Bench for phase_seq64: a simple master-FSM stand-in drives mast_state, and a
// timing model of each layer fills a queue that the monitor pops on every pulse.
module tb_phase_seq64;

    localparam int FSLD_W = 12;
    localparam int BLK_W  = 10;
    localparam int EV_W   = 42;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              layer_go = 1'b0;
    logic              hold = 1'b0;
    logic [2:0]        mast_state;
    logic [FSLD_W-1:0] cfg_fsld_len = '0;
    logic [BLK_W-1:0]  cfg_blk_len = '0;
    logic              start, flag_fsld_end, left_done, base_done, right_done;
    logic              active, layer_done, err;
    logic [6:0]        base_cnt;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int          layer_done_seen = 0;
    logic        mon_en = 1'b0;
    bit          hold_pat[512];
    logic [EV_W-1:0] exp_q[$];

    phase_seq64 #(.FSLD_W(FSLD_W), .BLK_W(BLK_W)) dut (
        .clk(clk), .reset(reset), .layer_go(layer_go), .hold(hold),
        .mast_state(mast_state), .cfg_fsld_len(cfg_fsld_len), .cfg_blk_len(cfg_blk_len),
        .start(start), .flag_fsld_end(flag_fsld_end), .left_done(left_done),
        .base_done(base_done), .right_done(right_done), .active(active),
        .layer_done(layer_done), .base_cnt(base_cnt), .err(err)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // master FSM stand-in: IDLE -> FSLD -> LEFT -> IDLE -> BASE x K -> RIGHT -> IDLE
    logic [2:0] fsm_st;
    logic       fsld_seen;
    int         bases_done;
    int         fsm_k = 0;
    logic       force_ill = 1'b0;
    assign mast_state = force_ill ? 3'd5 : fsm_st;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_st <= 3'd0; fsld_seen <= 1'b0; bases_done <= 0;
        end else begin
            case (fsm_st)
                3'd0: if (start) begin
                    if (!fsld_seen) fsm_st <= 3'd7;
                    else if (bases_done < fsm_k) fsm_st <= 3'd2;
                    else fsm_st <= 3'd3;
                end
                3'd7: if (flag_fsld_end) begin fsm_st <= 3'd1; fsld_seen <= 1'b1; end
                3'd1: if (left_done) fsm_st <= 3'd0;
                3'd2: if (base_done) begin fsm_st <= 3'd0; bases_done <= bases_done + 1; end
                3'd3: if (right_done) begin fsm_st <= 3'd0; fsld_seen <= 1'b0; bases_done <= 0; end
                default: fsm_st <= 3'd0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    function automatic logic [EV_W-1:0] mk_ev(input int kind, input int unsigned c, input int b);
        logic [2:0] k3;
        logic [6:0] b7;
        k3 = kind[2:0];
        b7 = b[6:0];
        return {k3, c, b7};
    endfunction

    function automatic bit hold_at(input int j);
        return (j < 512) ? hold_pat[j] : 1'b0;
    endfunction

    // reference model: each phase needs a number of non-hold cycles after layer_go
    task automatic push_layer(input int unsigned g, input int lf, input int lb, input int k);
        int lfe, lbe, n, idx;
        int work[$];
        int kind[$];
        int unsigned t_r;
        lfe = (lf == 0) ? 1 : lf;
        lbe = (lb == 0) ? 1 : lb;
        work.push_back(1 + lfe);       kind.push_back(0);
        work.push_back(1 + lfe + lbe); kind.push_back(1);
        for (int i = 1; i <= k; i++) begin
            work.push_back(1 + lfe + lbe + i * (1 + lbe)); kind.push_back(2);
        end
        work.push_back(1 + lfe + lbe + (k + 1) * (1 + lbe)); kind.push_back(3);
        n = 0; idx = 0; t_r = 0;
        for (int j = 0; idx < work.size(); j++) begin
            if (!hold_at(j)) begin
                n++;
                if (n == work[idx]) begin
                    exp_q.push_back(mk_ev(kind[idx], g + 1 + j, 0));
                    if (kind[idx] == 3) t_r = g + 1 + j;
                    idx++;
                end
            end
        end
        exp_q.push_back(mk_ev(4, t_r + 1, (k > 127) ? 127 : k));
    endtask

    // scoreboard monitor
    always @(negedge clk) begin : monitor
        logic [4:0] seen;
        logic [EV_W-1:0] e;
        if (mon_en) begin
            seen = {layer_done, right_done, base_done, left_done, flag_fsld_end};
            if (|seen[3:0]) chk("one_done_at_a_time", ($countones(seen[3:0]) <= 1), 1);
            for (int k = 0; k < 5; k++) begin
                if (seen[k]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse_kind", k, 7);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ev_kind", k, {29'd0, e[41:39]});
                        chk("ev_cycle", cyc, e[38:7]);
                        if (k == 4) begin
                            chk("base_cnt_at_layer_done", {25'd0, base_cnt}, {25'd0, e[6:0]});
                            chk("active_cleared", {31'd0, active}, 0);
                            layer_done_seen++;
                        end
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic clear_holds();
        for (int j = 0; j < 512; j++) hold_pat[j] = 1'b0;
    endtask

    task automatic rand_holds();
        for (int j = 0; j < 512; j++) hold_pat[j] = (j < 200) && ($urandom_range(0, 4) == 0);
    endtask

    task automatic do_reset();
        force_ill = 1'b0; layer_go = 1'b0; hold = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic run_layer(input int lf, input int lb, input int k, input bit inject_go);
        int unsigned g;
        int seen0;
        bit injected;
        injected = 1'b0;
        @(posedge clk); #1;
        cfg_fsld_len = lf[FSLD_W-1:0];
        cfg_blk_len  = lb[BLK_W-1:0];
        fsm_k = k;
        hold = 1'b0;
        layer_go = 1'b1;
        g = cyc;
        push_layer(g, lf, lb, k);
        seen0 = layer_done_seen;
        for (int j = 0; j < 3000; j++) begin
            @(posedge clk); #1;
            layer_go = 1'b0;
            hold = hold_at(j);
            if (j == 0) begin
                #1;
                chk("start_first_cycle", {31'd0, start}, {31'd0, ~hold});
                chk("active_after_go", {31'd0, active}, 1);
            end
            if (inject_go && !injected && fsm_st == 3'd2) begin
                layer_go = 1'b1;
                injected = 1'b1;
            end
            if (layer_done_seen != seen0) break;
        end
        hold = 1'b0;
        layer_go = 1'b0;
        if (layer_done_seen == seen0) begin
            checks++; errors++;
            $display("FAIL layer_timeout: got no layer_done expected one (lf=%0d lb=%0d k=%0d)", lf, lb, k);
            exp_q.delete();
        end
    endtask

    task automatic launch_quiet(input int lf, input int lb, input int k, input logic [2:0] until_st);
        int n;
        cfg_fsld_len = lf[FSLD_W-1:0];
        cfg_blk_len  = lb[BLK_W-1:0];
        fsm_k = k;
        @(posedge clk); #1 layer_go = 1'b1;
        @(posedge clk); #1 layer_go = 1'b0;
        n = 0;
        while (fsm_st != until_st && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (fsm_st != until_st) begin
            checks++; errors++;
            $display("FAIL wait_state: got %0d expected %0d", fsm_st, until_st);
        end
    endtask

    initial begin : main
        int starts;
        int bad;
        clear_holds();
        #2;
        chk("in_reset_start", {31'd0, start}, 0);
        chk("in_reset_active", {31'd0, active}, 0);
        do_reset();
        chk("reset_active", {31'd0, active}, 0);
        chk("reset_start", {31'd0, start}, 0);
        chk("reset_layer_done", {31'd0, layer_done}, 0);
        chk("reset_base_cnt", {25'd0, base_cnt}, 0);
        chk("reset_err", {31'd0, err}, 0);
        mon_en = 1'b1;

        run_layer(8, 4, 2, 1'b0);
        run_layer(0, 1, 2, 1'b0);
        clear_holds();
        for (int j = 15; j <= 17; j++) hold_pat[j] = 1'b1;
        run_layer(8, 4, 2, 1'b0);
        clear_holds();
        hold_pat[0] = 1'b1;
        hold_pat[1] = 1'b1;
        run_layer(5, 3, 3, 1'b1);
        clear_holds();
        run_layer(1, 1, 130, 1'b0);
        for (int r = 0; r < 8; r++) begin
            rand_holds();
            run_layer($urandom_range(0, 12), $urandom_range(0, 6), $urandom_range(0, 3),
                      $urandom_range(0, 1) == 1);
        end
        clear_holds();
        chk("queue_drained", exp_q.size(), 0);

        // async reset in the middle of RIGHT
        mon_en = 1'b0;
        launch_quiet(4, 6, 1, 3'd3);
        chk("base_cnt_before_reset", {25'd0, base_cnt}, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_active", {31'd0, active}, 0);
        chk("async_rst_outputs",
            {24'd0, start, flag_fsld_end, left_done, base_done, right_done, layer_done, err, 1'b0}, 0);
        chk("async_rst_base_cnt", {25'd0, base_cnt}, 0);
        @(posedge clk); #1 reset = 1'b1;
        starts = 0;
        repeat (12) begin
            @(negedge clk);
            if (start) starts++;
        end
        chk("no_start_after_reset", starts, 0);

        // illegal master state while active
        launch_quiet(3, 5, 1, 3'd1);
        chk("err_before_illegal", {31'd0, err}, 0);
        force_ill = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (flag_fsld_end | left_done | base_done | right_done) bad++;
        end
        @(posedge clk); #1 force_ill = 1'b0;
        chk("no_done_in_illegal", bad, 0);
        chk("err_set", {31'd0, err}, 1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!err) bad++;
        end
        chk("err_sticky", bad, 0);
        do_reset();
        chk("err_cleared_by_reset", {31'd0, err}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
